// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared CPU definitions for the rename/commit register-file controller
package regfile_ctrl_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int ROB_W_DEF  = 4;
    localparam logic [ROB_W_DEF-1:0] TAG_NONE = '0;
    typedef enum logic [1:0] {RUN, DRAIN, WALK} state_t;
endpackage

// File: rtl/regfile_port_buf.sv
// regfile_port_buf: one-entry buffer replaying an accepted transfer as a single-cycle write strobe
module regfile_port_buf #(
    parameter int IDX_W = 5,
    parameter int PAY_W = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             drop,
    input  logic [IDX_W-1:0] idx,
    input  logic [PAY_W-1:0] pay,
    output logic             st_en,
    output logic [IDX_W-1:0] st_idx,
    output logic [PAY_W-1:0] st_pay
);
    logic             v;
    logic [IDX_W-1:0] b_idx;
    logic [PAY_W-1:0] b_pay;
    always_ff @(posedge clk) begin
        if (rst) begin
            v     <= 1'b0;
            b_idx <= '0;
            b_pay <= '0;
        end else if (en) begin
            v <= load && idx != '0;
            if (load) begin
                b_idx <= idx;
                b_pay <= pay;
            end
        end
    end
    assign st_en  = v & en & ~drop;
    assign st_idx = st_en ? b_idx : '0;
    assign st_pay = st_en ? b_pay : '0;
endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: commit/rename write sequencing with flush drain and rename-bit clear walk
// Optional REGFILE_CTRL_STATS_EN adds saturating stat_commits / stat_flushes counters.
module regfile_ctrl import regfile_ctrl_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int ROB_W  = ROB_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              cm_valid,
    output logic              cm_ready,
    input  logic [REG_W-1:0]  cm_idx,
    input  logic [ROB_W-1:0]  cm_tag,
    input  logic [DATA_W-1:0] cm_value,
    input  logic              rn_valid,
    output logic              rn_ready,
    input  logic [REG_W-1:0]  rn_idx,
    input  logic [ROB_W-1:0]  rn_tag,
    input  logic              flush,
    output logic              rf_cm_en,
    output logic [REG_W-1:0]  rf_cm_idx,
    output logic [ROB_W-1:0]  rf_cm_tag,
    output logic [DATA_W-1:0] rf_cm_value,
    output logic              rf_rn_en,
    output logic [REG_W-1:0]  rf_rn_idx,
    output logic [ROB_W-1:0]  rf_rn_tag,
    output logic              rf_clr_en,
    output logic [REG_W-1:0]  rf_clr_idx,
    output logic              busy
`ifdef REGFILE_CTRL_STATS_EN
    ,
    output logic [31:0]       stat_commits,
    output logic [15:0]       stat_flushes
`endif
);
    localparam logic [REG_W:0] LAST = {1'b0, {REG_W{1'b1}}};
    state_t           state, state_n;
    logic [REG_W:0]   cnt, cnt_n;
    logic             go, run, take_flush;
    logic [ROB_W+DATA_W-1:0] cm_pay;
    assign go         = rdy & ~rst;
    assign run        = state == RUN;
    assign take_flush = go & run & flush;
    assign cm_ready   = go & run;
    assign rn_ready   = go & run;
    regfile_port_buf #(.IDX_W(REG_W), .PAY_W(ROB_W + DATA_W)) u_cm (
        .clk(clk), .rst(rst), .en(go), .load(cm_valid & cm_ready), .drop(1'b0),
        .idx(cm_idx), .pay({cm_tag, cm_value}),
        .st_en(rf_cm_en), .st_idx(rf_cm_idx), .st_pay(cm_pay)
    );
    assign {rf_cm_tag, rf_cm_value} = cm_pay;
    // a flush kills the rename taken this cycle and suppresses the one still pending
    regfile_port_buf #(.IDX_W(REG_W), .PAY_W(ROB_W)) u_rn (
        .clk(clk), .rst(rst), .en(go), .load(rn_valid & rn_ready & ~flush), .drop(flush & run),
        .idx(rn_idx), .pay(rn_tag),
        .st_en(rf_rn_en), .st_idx(rf_rn_idx), .st_pay(rf_rn_tag)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (go) begin
            unique case (state)
                RUN:   state_n = flush ? DRAIN : RUN;
                DRAIN: begin
                    state_n = WALK;
                    cnt_n   = (REG_W+1)'(1);
                end
                WALK: begin
                    state_n = cnt == LAST ? RUN : WALK;
                    cnt_n   = cnt == LAST ? '0 : cnt + 1'b1;
                end
                default: state_n = RUN;
            endcase
        end
    end
    assign rf_clr_en  = go & (state == WALK);
    assign rf_clr_idx = rf_clr_en ? cnt[REG_W-1:0] : '0;
    assign busy       = ~rst & ~run;
`ifdef REGFILE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_commits <= '0;
            stat_flushes <= '0;
        end else begin
            if (rf_cm_en && !(&stat_commits)) stat_commits <= stat_commits + 1'b1;
            if (take_flush && !(&stat_flushes)) stat_flushes <= stat_flushes + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: vector table, corner sequences and randomized run against a timeline model
module tb_regfile_ctrl;
    logic        clk = 0, rst = 1, rdy = 0, flush = 0;
    logic        cm_valid = 0, rn_valid = 0;
    logic [4:0]  cm_idx = 0, rn_idx = 0;
    logic [3:0]  cm_tag = 0, rn_tag = 0;
    logic [31:0] cm_value = 0;
    logic        cm_ready, rn_ready, rf_cm_en, rf_rn_en, rf_clr_en, busy;
    logic [4:0]  rf_cm_idx, rf_rn_idx, rf_clr_idx;
    logic [3:0]  rf_cm_tag, rf_rn_tag;
    logic [31:0] rf_cm_value;
    int n_tests = 0, n_fail = 0;

    regfile_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_idx(cm_idx), .cm_tag(cm_tag), .cm_value(cm_value),
        .rn_valid(rn_valid), .rn_ready(rn_ready), .rn_idx(rn_idx), .rn_tag(rn_tag),
        .flush(flush),
        .rf_cm_en(rf_cm_en), .rf_cm_idx(rf_cm_idx), .rf_cm_tag(rf_cm_tag), .rf_cm_value(rf_cm_value),
        .rf_rn_en(rf_rn_en), .rf_rn_idx(rf_rn_idx), .rf_rn_tag(rf_rn_tag),
        .rf_clr_en(rf_clr_en), .rf_clr_idx(rf_clr_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // model: phase 0 = normal, 1 = drain cycle, 2..32 = clearing register phase-1
    int          m = 0;
    logic        pc_v = 0, pr_v = 0;
    logic [4:0]  pc_idx, pr_idx;
    logic [3:0]  pc_tag, pr_tag;
    logic [31:0] pc_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        logic go, e_rdy, e_cm, e_rn, e_clr;
        #1;
        go    = rdy && !rst;
        e_rdy = go && m == 0;
        e_cm  = go && pc_v;
        e_rn  = go && pr_v && !(m == 0 && flush);
        e_clr = go && m >= 2;
        chk("m_cm_ready", cm_ready, e_rdy);
        chk("m_rn_ready", rn_ready, e_rdy);
        chk("m_busy", busy, !rst && m != 0);
        chk("m_cm_en", rf_cm_en, e_cm);
        chk("m_cm_idx", rf_cm_idx, e_cm ? pc_idx : 0);
        chk("m_cm_tag", rf_cm_tag, e_cm ? pc_tag : 0);
        chk("m_cm_val", rf_cm_value, e_cm ? pc_val : 0);
        chk("m_rn_en", rf_rn_en, e_rn);
        chk("m_rn_idx", rf_rn_idx, e_rn ? pr_idx : 0);
        chk("m_rn_tag", rf_rn_tag, e_rn ? pr_tag : 0);
        chk("m_clr_en", rf_clr_en, e_clr);
        chk("m_clr_idx", rf_clr_idx, e_clr ? 64'(m - 1) : 0);
    endtask

    task automatic tick();
        logic acc;
        @(posedge clk);
        if (rst) begin
            m = 0; pc_v = 0; pr_v = 0;
        end else if (rdy) begin
            acc  = m == 0;
            pc_v = acc && cm_valid && cm_idx != 0;
            pc_idx = cm_idx; pc_tag = cm_tag; pc_val = cm_value;
            pr_v = acc && rn_valid && !flush && rn_idx != 0;
            pr_idx = rn_idx; pr_tag = rn_tag;
            m = m == 0 ? (flush ? 1 : 0) : (m == 32 ? 0 : m + 1);
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; rdy = 1; flush = 0; cm_valid = 0; rn_valid = 0;
    endtask

    typedef struct packed {
        logic rdy, rst, flush, cv;
        logic [4:0] ci; logic [3:0] ct; logic [31:0] cval;
        logic rv; logic [4:0] ri; logic [3:0] rt;
        logic e_cm; logic [4:0] e_ci; logic [3:0] e_ct; logic [31:0] e_cv;
        logic e_rn; logic [4:0] e_ri; logic [3:0] e_rt;
        logic e_rdy, e_busy;
    } vec_t;

    function automatic vec_t mk(input logic r, s, f, cv, input logic [4:0] ci, input logic [3:0] ct,
                                input logic [31:0] cval, input logic rv, input logic [4:0] ri,
                                input logic [3:0] rt, input logic e_cm, input logic [4:0] e_ci,
                                input logic [3:0] e_ct, input logic [31:0] e_cv, input logic e_rn,
                                input logic [4:0] e_ri, input logic [3:0] e_rt, input logic e_rdy);
        return '{r, s, f, cv, ci, ct, cval, rv, ri, rt, e_cm, e_ci, e_ct, e_cv, e_rn, e_ri, e_rt, e_rdy, 1'b0};
    endfunction

    vec_t tbl[14];
    int   busy_cnt;

    initial begin
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 0, 0, 1);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0,            1, 0, 2, 0, 0, 0, 0,            0, 0, 0, 1);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1);
        tbl[6]  = mk(1, 0, 0, 1, 7, 1, 32'h12345678, 1, 7, 9, 0, 0, 0, 0,            0, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 7, 1, 32'h12345678, 1, 7, 9, 1);
        tbl[8]  = mk(0, 0, 0, 1, 3, 2, 5,            0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1);
        tbl[10] = mk(1, 0, 0, 1, 9, 4, 32'hA5,       0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 9, 4, 32'hA5,       0, 0, 0, 1);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1);

        @(posedge clk); #1;
        for (int i = 0; i < 14; i++) begin
            rdy = tbl[i].rdy; rst = tbl[i].rst; flush = tbl[i].flush;
            cm_valid = tbl[i].cv; cm_idx = tbl[i].ci; cm_tag = tbl[i].ct; cm_value = tbl[i].cval;
            rn_valid = tbl[i].rv; rn_idx = tbl[i].ri; rn_tag = tbl[i].rt;
            settle();
            chk($sformatf("t%0d_cm_en", i), rf_cm_en, tbl[i].e_cm);
            chk($sformatf("t%0d_cm_idx", i), rf_cm_idx, tbl[i].e_ci);
            chk($sformatf("t%0d_cm_tag", i), rf_cm_tag, tbl[i].e_ct);
            chk($sformatf("t%0d_cm_val", i), rf_cm_value, tbl[i].e_cv);
            chk($sformatf("t%0d_rn_en", i), rf_rn_en, tbl[i].e_rn);
            chk($sformatf("t%0d_rn_idx", i), rf_rn_idx, tbl[i].e_ri);
            chk($sformatf("t%0d_rn_tag", i), rf_rn_tag, tbl[i].e_rt);
            chk($sformatf("t%0d_ready", i), cm_ready & rn_ready, tbl[i].e_rdy);
            chk($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
            tick();
        end

        // flush with a commit and a rename taken in the same cycle
        idle(); flush = 1; cm_valid = 1; cm_idx = 4; cm_tag = 5; cm_value = 32'h44;
        rn_valid = 1; rn_idx = 6; rn_tag = 7;
        settle(); chk("fl_ready", cm_ready, 1); chk("fl_busy0", busy, 0); tick();
        idle(); busy_cnt = 0;
        settle();
        chk("drain_cm_en", rf_cm_en, 1); chk("drain_cm_idx", rf_cm_idx, 4);
        chk("drain_rn_en", rf_rn_en, 0); chk("drain_ready", cm_ready | rn_ready, 0);
        if (busy) busy_cnt++;
        tick();
        for (int k = 1; k <= 31; k++) begin
            settle();
            chk($sformatf("walk_clr_idx%0d", k), rf_clr_idx, k);
            chk("walk_clr_en", rf_clr_en, 1);
            chk("walk_rn_en", rf_rn_en, 0);
            if (busy) busy_cnt++;
            tick();
        end
        settle();
        chk("walk_busy_cycles", busy_cnt, 32);
        chk("post_busy", busy, 0); chk("post_ready", rn_ready, 1); chk("post_clr", rf_clr_en, 0);
        tick();

        // rst in the middle of a walk
        idle(); flush = 1; settle(); tick();
        idle(); settle(); tick();
        for (int k = 1; k < 10; k++) begin settle(); tick(); end
        rst = 1; settle(); chk("rst_walk_idx_pre", dut.cnt, 10); tick();
        idle(); settle();
        chk("rst_walk_busy", busy, 0); chk("rst_walk_clr", rf_clr_en, 0); chk("rst_walk_ready", cm_ready, 1);
        tick();

        // flush ignored while walking
        idle(); flush = 1; settle(); tick();
        idle(); settle(); tick();
        busy_cnt = 1;
        for (int k = 1; k <= 31; k++) begin
            flush = (k % 3) == 0;
            settle();
            chk($sformatf("wf_clr_idx%0d", k), rf_clr_idx, k);
            if (busy) busy_cnt++;
            tick();
        end
        idle(); settle(); chk("wf_busy_cycles", busy_cnt, 32); chk("wf_done", busy, 0); tick();

        // pending rename dropped by a flush in the following cycle
        idle(); rn_valid = 1; rn_idx = 12; rn_tag = 3; settle(); tick();
        idle(); flush = 1; settle(); chk("pend_rn_drop", rf_rn_en, 0); tick();
        idle(); for (int k = 0; k < 32; k++) begin settle(); tick(); end

        for (int c = 0; c < 1500; c++) begin
            rst = $urandom_range(99) == 0;
            rdy = $urandom_range(9) != 0;
            flush = $urandom_range(24) == 0;
            cm_valid = $urandom_range(1); cm_idx = 5'($urandom); cm_tag = 4'($urandom); cm_value = $urandom;
            rn_valid = $urandom_range(1); rn_idx = 5'($urandom); rn_tag = 4'($urandom);
            if ($urandom_range(7) == 0) cm_idx = 0;
            if ($urandom_range(7) == 0) rn_idx = cm_idx;
            settle(); tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: DATA_W, 32, register value width; REG_W, 5, architectural register index width; ROB_W, 4, ROB tag width.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global enable; when low, all state holds, all *_ready are 0 and no write strobes are driven.
REQ-005 cm_valid/cm_ready  input/output  1/1  ROB commit handshake; cm_idx REG_W, cm_tag ROB_W, cm_value DATA_W inputs.
REQ-006 rn_valid/rn_ready  input/output  1/1  decoder rename handshake; rn_idx REG_W, rn_tag ROB_W inputs.
REQ-007 flush  input  1  misprediction flush pulse.
REQ-008 rf_cm_en, rf_cm_idx, rf_cm_tag, rf_cm_value  outputs  1/REG_W/ROB_W/DATA_W  regfile commit write port.
REQ-009 rf_rn_en, rf_rn_idx, rf_rn_tag  outputs  1/REG_W/ROB_W  regfile rename write port.
REQ-010 rf_clr_en, rf_clr_idx  outputs  1/REG_W  clear one register's rename bit.
REQ-011 busy  output  1  high whenever state is not RUN.

Function
REQ-012 A transfer SHALL occur on a port when valid and ready are both high at posedge with rdy high.
REQ-013 Each port SHALL hold a one-entry buffer; an accepted transfer SHALL appear on its rf_* strobe exactly one cycle later for one cycle.
REQ-014 In RUN, cm_ready and rn_ready SHALL be 1 (buffer drains every cycle, so no back-pressure).
REQ-015 Transfers with index 0 SHALL complete the handshake but produce no rf_* strobe.
REQ-016 Commit and rename to the same index in the same cycle SHALL both be issued in the same cycle; the regfile applies rename priority.
REQ-017 FSM states SHALL be RUN, DRAIN, WALK.
REQ-018 RUN + flush: next state DRAIN; a commit accepted in the flush cycle SHALL be kept; a rename accepted in the flush cycle or pending SHALL be discarded.
REQ-019 DRAIN (one cycle): pending commit issued; cm_ready=rn_ready=0; next state WALK with walk counter = 1.
REQ-020 WALK: rf_clr_en=1, rf_clr_idx=counter each cycle, counter increments; after index 31 (2^REG_W-1) next state RUN; 31 cycles total; both ready outputs 0.
REQ-021 flush in DRAIN or WALK SHALL be ignored.
REQ-022 Walk counter SHALL be REG_W+1 bits so the terminal comparison does not wrap.

Reset
REQ-023 rst SHALL force state RUN, clear both buffers, walk counter 0, all rf_*_en 0, busy 0, statistics 0; rst overrides flush and rdy and aborts any walk in progress.
REQ-024 All data outputs SHALL be 0 in reset.

Configuration
REQ-025 Macro REGFILE_CTRL_STATS_EN SHALL, when defined, add outputs stat_commits (32b, counts rf_cm_en strobes) and stat_flushes (16b, counts RUN->DRAIN transitions), both saturating.
REQ-026 Without REGFILE_CTRL_STATS_EN the ports SHALL be absent and no counter logic synthesised; all other behaviour is identical.

Structure
REQ-027 State encoding (RUN/DRAIN/WALK), width defaults and the not-renamed tag constant SHALL live in the shared CPU definitions package.
REQ-028 The one-entry port buffer SHALL be a sub-module regfile_port_buf, instantiated twice (commit, rename).

Verification
REQ-029 Commit idx=5 tag=3 value=0xDEADBEEF at cycle N -> rf_cm_en=1 with those values at N+1 only.
REQ-030 Rename idx=0 tag=2 -> rn_ready=1, no rf_rn_en ever.
REQ-031 Commit idx=7 and rename idx=7 tag=9 same cycle -> both strobes at N+1.
REQ-032 flush with commit idx=4 and rename idx=6 accepted -> commit issued in DRAIN, no rename strobe, then rf_clr_idx 1..31 over 31 cycles, busy high 32 cycles, RUN after.
REQ-033 rst asserted at WALK index 10 -> next cycle RUN, busy 0, no rf_clr_en.
REQ-034 flush during WALK -> ignored, walk completes at 31 unchanged.
